unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one 128-bit block main memory between the instruction-cache and data-cache miss ports.
//  Sits between the two caches and a single data_memory-style backing store.
//  Serialises block reads (I and D) and block write-backs (D only) with the codebase busywait handshake.
//  Returns the fill data to the requester that owns the transaction.
// PARAMETERS
//  ADDR_W   28   block address width (word address >> 2)
//  BLOCK_W  128  block data width
// PORTS
//  CLK            in   1        clock; all state updates on posedge
//  RESET          in   1        asynchronous, active-low reset (0 = reset)
//  i_read         in   1        I-cache block read request (level, held until i_busywait low)
//  i_address      in   ADDR_W   I-cache block address
//  i_readdata     out  BLOCK_W  block returned to I-cache
//  i_busywait     out  1        I-cache stall
//  d_read         in   1        D-cache block read request
//  d_write        in   1        D-cache block write-back request
//  d_address      in   ADDR_W   D-cache block address
//  d_writedata    in   BLOCK_W  D-cache write-back block
//  d_readdata     out  BLOCK_W  block returned to D-cache
//  d_busywait     out  1        D-cache stall
//  mem_read       out  1        memory read strobe
//  mem_write      out  1        memory write strobe
//  mem_address    out  ADDR_W   memory block address
//  mem_writedata  out  BLOCK_W  memory write block
//  mem_readdata   in   BLOCK_W  memory read block
//  mem_busywait   in   1        memory busy
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE, owner=I, mem_read=mem_write=0, mem_address=0, mem_writedata=0,
//   i_readdata=d_readdata=0, started=0, rr_last=D. Outputs go low immediately, not at the next edge.
//  Reset mid-transaction: the memory op is abandoned; no readdata update; requesters restart after reset.
//  States: IDLE -> ISSUE -> DONE -> IDLE.
//  IDLE:
//   - If any request is pending, select a winner and latch owner, address, writedata and op.
//   - Drive mem_read/mem_write registered from the next edge; go to ISSUE.
//   - No request: stay in IDLE, memory strobes low.
//  ISSUE:
//   - Hold mem_* stable.
//   - Set started=1 on the first cycle in which mem_busywait=1.
//   - When started=1 and mem_busywait=0: capture mem_readdata into the owner's readdata register
//     (reads only), drop mem strobes, clear started, go to DONE.
//  DONE:
//   - One cycle. The owner's busywait is low for exactly this cycle; the requester drops its strobe at this edge.
//   - Next state is IDLE, so back-to-back ops cost min 1 idle cycle.
//  Busywait decode (combinational):
//   - i_busywait = i_read & ~(state==DONE & owner==I).
//   - d_busywait = (d_read|d_write) & ~(state==DONE & owner==D).
//  Latency: request to busywait-low = 2 cycles + memory busy time.
//  Readdata registers hold their value until the next read by the same port.
//  Selection when both request in IDLE: see CONFIGURATION. A single request is always granted.
//  d_read & d_write together: treated as write (protocol error, no flag).
//  Requester drops its strobe mid-ISSUE: the memory op still completes.
//   - Read data is still captured.
//   - DONE still occurs; its busywait deassert is harmless.
//  Requests arriving during ISSUE/DONE wait with busywait high; they are not sampled until IDLE.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - Simultaneous I/D requests are granted to the port not in rr_last.
//   - rr_last updates to the owner on every grant.
//  Not defined: fixed priority, D-cache always wins ties; rr_last is unused (constant D).
// TESTING
//  1 Single I read of 0x0000010, memory busy 5 cycles
//    -> i_readdata = mem block; i_busywait low exactly 1 cycle; d_busywait 0 throughout.
//  2 D write-back to 0x0000020 (data 0xA5..A5) -> mem_write=1, mem_address=0x20, mem_writedata=0xA5..A5;
//    d_readdata unchanged.
//  3 I read and D read asserted in the same cycle (both addr 0x4), fixed priority
//    -> D served first, then I; neither busywait drops early.
//  4 Same as 3 with ARB_ROUND_ROBIN_EN, four tie rounds -> grants alternate I,D,I,D (first I since rr_last=D).
//  5 RESET pulsed low mid-ISSUE -> mem_read=0 immediately; state IDLE; readdata = 0;
//    the retried request completes correctly.
//  6 d_read and d_write both high -> memory sees write only; d_readdata unchanged.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// I-cache, D-cache and backing-store miss signals for the shared block memory arbiter.
// slave is the arbiter's view; master is the caches/memory side.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W  = 28,
   parameter int BLOCK_W = 128
);
   logic               i_read;
   logic [ADDR_W-1:0]  i_address;
   logic [BLOCK_W-1:0] i_readdata;
   logic               i_busywait;

   logic               d_read;
   logic               d_write;
   logic [ADDR_W-1:0]  d_address;
   logic [BLOCK_W-1:0] d_writedata;
   logic [BLOCK_W-1:0] d_readdata;
   logic               d_busywait;

   logic               mem_read;
   logic               mem_write;
   logic [ADDR_W-1:0]  mem_address;
   logic [BLOCK_W-1:0] mem_writedata;
   logic [BLOCK_W-1:0] mem_readdata;
   logic               mem_busywait;

   modport slave (
      input  i_read, i_address,
      output i_readdata, i_busywait,
      input  d_read, d_write, d_address, d_writedata,
      output d_readdata, d_busywait,
      output mem_read, mem_write, mem_address, mem_writedata,
      input  mem_readdata, mem_busywait
   );

   modport master (
      output i_read, i_address,
      input  i_readdata, i_busywait,
      output d_read, d_write, d_address, d_writedata,
      input  d_readdata, d_busywait,
      input  mem_read, mem_write, mem_address, mem_writedata,
      output mem_readdata, mem_busywait
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises I/D block reads and D write-backs onto one memory; ties go to D unless ARB_ROUND_ROBIN_EN.
// Latency request->busywait low = 2 cycles + memory busy time; requests stall on busywait while another op runs.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 28,
   parameter int BLOCK_W = 128
) (
   input logic                 CLK,
   input logic                 RESET,
   unified_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t             state;
   logic               owner;
   logic               started;
   logic               mem_read_q;
   logic               mem_write_q;
   logic [ADDR_W-1:0]  mem_address_q;
   logic [BLOCK_W-1:0] mem_writedata_q;
   logic [BLOCK_W-1:0] i_readdata_q;
   logic [BLOCK_W-1:0] d_readdata_q;

   logic i_req;
   logic d_req;
   logic grant_d;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last;
   assign grant_d = d_req & (~i_req | (rr_last == OWN_I));
`else
   assign grant_d = d_req;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state           <= IDLE;
         owner           <= OWN_I;
         started         <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         i_readdata_q    <= '0;
         d_readdata_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last         <= OWN_D;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  owner           <= grant_d;
                  mem_address_q   <= grant_d ? bus.d_address : bus.i_address;
                  mem_writedata_q <= bus.d_writedata;
                  // read+write together from the D side resolves to a write
                  mem_read_q      <= grant_d ? ~bus.d_write : 1'b1;
                  mem_write_q     <= grant_d & bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
                  rr_last         <= grant_d;
`endif
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (!started) begin
                  if (bus.mem_busywait)
                     started <= 1'b1;
               end else if (!bus.mem_busywait) begin
                  if (mem_read_q) begin
                     if (owner == OWN_D)
                        d_readdata_q <= bus.mem_readdata;
                     else
                        i_readdata_q <= bus.mem_readdata;
                  end
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  started     <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_address   = mem_address_q;
   assign bus.mem_writedata = mem_writedata_q;
   assign bus.i_readdata    = i_readdata_q;
   assign bus.d_readdata    = d_readdata_q;

   assign bus.i_busywait = bus.i_read & ~((state == DONE) && (owner == OWN_I));
   assign bus.d_busywait = d_req & ~((state == DONE) && (owner == OWN_D));
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: behavioural memory, I/D requesters, decoupled monitor.
module tb_unified_mem_arbiter;
   localparam int AW = 28;
   localparam int BW = 128;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   unified_mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();
   unified_mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   typedef struct {bit rd; logic [127:0] data;} dexp_t;
   logic [127:0] i_q[$];
   dexp_t        d_q[$];
   bit           ord_q[$];     // expected completion order, 0 = I, 1 = D

   logic [127:0] mem[64];      // physical store behind the memory model
   logic [127:0] ref_mem[64];  // reference view in request order
   logic [127:0] last_d;
   int           mem_lat    = 3;
   bit           rand_lat   = 1'b0;
   int           mem_rd_cnt = 0;
   int           mem_wr_cnt = 0;
   logic [27:0]  last_w_addr = '0;
   logic [127:0] last_w_data = '0;

   // Backing store: busywait high for the latency in cycles, result presented as it drops
   initial begin
      bit           cur_w;
      logic [27:0]  cur_a;
      logic [127:0] cur_d;
      int           cnt;
      bus.mem_busywait = 1'b0;
      bus.mem_readdata = '0;
      cur_w = 1'b0; cur_a = '0; cur_d = '0; cnt = 0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            bus.mem_busywait = 1'b0;
         end else if (!bus.mem_busywait) begin
            if (bus.mem_read || bus.mem_write) begin
               chk(!(bus.mem_read && bus.mem_write), "mem_single_strobe",
                   {bus.mem_read, bus.mem_write}, 2'b01);
               cur_w = bus.mem_write;
               cur_a = bus.mem_address;
               cur_d = bus.mem_writedata;
               cnt   = rand_lat ? $urandom_range(1, 6) : mem_lat;
               bus.mem_busywait = 1'b1;
               bus.mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            end
         end else begin
            chk(bus.mem_address == cur_a && bus.mem_write == cur_w && bus.mem_read == !cur_w,
                "mem_stable", bus.mem_address, cur_a);
            cnt--;
            if (cnt == 0) begin
               bus.mem_busywait = 1'b0;
               if (cur_w) begin
                  mem[cur_a[5:0]] = cur_d;
                  mem_wr_cnt++;
                  last_w_addr = cur_a;
                  last_w_data = cur_d;
               end else begin
                  bus.mem_readdata = mem[cur_a[5:0]];
                  mem_rd_cnt++;
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever a requester sees its busywait drop
   initial begin
      logic [127:0] e;
      dexp_t        de;
      bit           o;
      forever begin
         @(negedge CLK);
         if (!bus.i_read)
            chk(!bus.i_busywait, "i_busywait_no_req", bus.i_busywait, 0);
         if (!(bus.d_read || bus.d_write))
            chk(!bus.d_busywait, "d_busywait_no_req", bus.d_busywait, 0);
         if (bus.i_read && !bus.i_busywait) begin
            if (i_q.size() == 0) begin
               chk(1'b0, "i_unexpected_done", 1, 0);
            end else begin
               e = i_q.pop_front();
               chk(bus.i_readdata == e, "i_readdata", bus.i_readdata, e);
            end
            if (ord_q.size() != 0) begin
               o = ord_q.pop_front();
               chk(o == 1'b0, "grant_order_i", 0, o);
            end
         end
         if ((bus.d_read || bus.d_write) && !bus.d_busywait) begin
            if (d_q.size() == 0) begin
               chk(1'b0, "d_unexpected_done", 1, 0);
            end else begin
               de = d_q.pop_front();
               chk(bus.d_readdata == de.data, de.rd ? "d_readdata" : "d_readdata_kept",
                   bus.d_readdata, de.data);
            end
            if (ord_q.size() != 0) begin
               o = ord_q.pop_front();
               chk(o == 1'b1, "grant_order_d", 1, o);
            end
         end
      end
   end

   task automatic i_access(input logic [27:0] a, output int lat);
      i_q.push_back(ref_mem[a[5:0]]);
      @(posedge CLK); #1;
      bus.i_address = a;
      bus.i_read    = 1'b1;
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (bus.i_busywait && lat < 500);
      chk(!bus.i_busywait, "i_timeout", lat, 500);
      @(posedge CLK); #1;
      bus.i_read = 1'b0;
   endtask

   // op: 0 read, 1 write-back, 2 read and write together (behaves as write)
   task automatic d_access(input int op, input logic [27:0] a, input logic [127:0] wd);
      int n;
      if (op == 0) begin
         d_q.push_back('{1'b1, ref_mem[a[5:0]]});
         last_d = ref_mem[a[5:0]];
      end else begin
         d_q.push_back('{1'b0, last_d});
         ref_mem[a[5:0]] = wd;
      end
      @(posedge CLK); #1;
      bus.d_address   = a;
      bus.d_writedata = wd;
      bus.d_read      = (op != 1);
      bus.d_write     = (op != 0);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (bus.d_busywait && n < 500);
      chk(!bus.d_busywait, "d_timeout", n, 500);
      @(posedge CLK); #1;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      int           li;
      int           rd_before;
      bit           rr_model;
      bit           first;
      logic [127:0] v;
      logic [127:0] a5;
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
      for (int a = 0; a < 64; a++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         mem[a]     = v;
         ref_mem[a] = v;
      end
      last_d   = '0;
      rr_model = 1'b1;

      #2 RESET = 1'b0;
      #1;
      chk(bus.mem_read == 0,      "rst_mem_read", bus.mem_read, 0);
      chk(bus.mem_write == 0,     "rst_mem_write", bus.mem_write, 0);
      chk(bus.mem_address == 0,   "rst_mem_address", bus.mem_address, 0);
      chk(bus.mem_writedata == 0, "rst_mem_writedata", bus.mem_writedata, 0);
      chk(bus.i_readdata == 0,    "rst_i_readdata", bus.i_readdata, 0);
      chk(bus.d_readdata == 0,    "rst_d_readdata", bus.d_readdata, 0);
      chk(bus.i_busywait == 0,    "rst_i_busywait", bus.i_busywait, 0);
      chk(bus.d_busywait == 0,    "rst_d_busywait", bus.d_busywait, 0);
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b1;

      // single I read, 5 busy cycles: busywait low 2 + 5 cycles after the request
      mem_lat = 5;
      i_access(28'h10, lat);
      chk(lat == mem_lat + 3, "i_latency_negedges", lat, mem_lat + 3);

      // D write-back
      mem_lat = 3;
      a5 = {16{8'hA5}};
      d_access(1, 28'h20, a5);
      chk(last_w_addr == 28'h20, "wb_address", last_w_addr, 28'h20);
      chk(last_w_data == a5,     "wb_data", last_w_data, a5);

      // tie rounds: both ports request block 0x4 in the same cycle
      for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
         first = ~rr_model;
`else
         first = 1'b1;
`endif
         ord_q.push_back(first);
         ord_q.push_back(~first);
         rr_model = ~first;
         fork
            i_access(28'h4, li);
            d_access(0, 28'h4, '0);
         join
      end

      // read and write together: memory sees only the write
      rd_before = mem_rd_cnt;
      v = {$urandom, $urandom, $urandom, $urandom};
      d_access(2, 28'h25, v);
      chk(mem_rd_cnt == rd_before, "rw_no_mem_read", mem_rd_cnt, rd_before);
      chk(last_w_addr == 28'h25 && last_w_data == v, "rw_write_data", last_w_data, v);
      d_access(0, 28'h25, '0);

      // concurrent random traffic; D writes stay clear of the I address range
      rand_lat = 1'b1;
      fork
         begin
            int ri;
            repeat (40) begin
               repeat ($urandom_range(0, 3)) @(posedge CLK);
               i_access(28'($urandom_range(0, 31)), ri);
            end
         end
         begin
            int op;
            repeat (40) begin
               repeat ($urandom_range(0, 3)) @(posedge CLK);
               op = $urandom_range(0, 2);
               d_access(op, (op == 0) ? 28'($urandom_range(0, 63)) : 28'($urandom_range(32, 63)),
                        {$urandom, $urandom, $urandom, $urandom});
            end
         end
      join
      rand_lat = 1'b0;

      // reset mid-transaction, request held through it and retried
      mem_lat = 8;
      fork
         i_access(28'h9, li);
         begin
            int k;
            k = 0;
            while (!bus.mem_read && k < 50) begin
               @(negedge CLK);
               k++;
            end
            chk(bus.mem_read == 1'b1, "rst_test_issue", bus.mem_read, 1);
            repeat (2) @(posedge CLK);
            #2 RESET = 1'b0;
            #1;
            chk(bus.mem_read == 0,   "midrst_mem_read", bus.mem_read, 0);
            chk(bus.i_readdata == 0, "midrst_i_readdata", bus.i_readdata, 0);
            chk(bus.d_readdata == 0, "midrst_d_readdata", bus.d_readdata, 0);
            chk(bus.i_busywait == 1, "midrst_i_busywait", bus.i_busywait, 1);
            last_d = '0;
            @(posedge CLK);
            #2 RESET = 1'b1;
         end
      join
      mem_lat = 2;
      d_access(1, 28'h30, {$urandom, $urandom, $urandom, $urandom});
      d_access(0, 28'h30, '0);

      repeat (3) @(posedge CLK);
      chk(i_q.size() == 0,   "i_queue_drained", i_q.size(), 0);
      chk(d_q.size() == 0,   "d_queue_drained", d_q.size(), 0);
      chk(ord_q.size() == 0, "order_queue_drained", ord_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
